sd_sector_scheduler: RTL and testbench

- Sequences an SD-card SPI write controller, the counterpart of the FIFO-fed SD logger path.
- Watches the write-FIFO fill level and issues one-sector write commands at auto-incrementing sector addresses.
- Handles a flush request by zero-padding a partial sector, and watchdogs the controller busy line.
- Sits between the write FIFO / SD controller pair and the system control logic.

---
 rtl/sd_sched_pkg.sv | 19 +
 rtl/sd_busy_watchdog.sv | 31 +++
 rtl/sd_sector_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_sd_sector_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_sched_pkg.sv
// Shared types and default constants for the SD sector write scheduler.
package sd_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT      = 3'd1,
    S_START     = 3'd2,
    S_BUSY_WAIT = 3'd3,
    S_BUSY      = 3'd4,
    S_NEXT      = 3'd5
  } sched_state_e;

  localparam int unsigned TIMEOUT_W            = 32'd24;
  localparam int unsigned DEF_WORDS_PER_SECTOR = 32'd256;
  localparam logic [31:0] DEF_START_SECTOR     = 32'd1000;
  localparam logic [31:0] DEF_END_SECTOR       = 32'd1_000_000;
  localparam logic [TIMEOUT_W-1:0] DEF_BUSY_TIMEOUT = 24'd5_000_000;

endpackage

// File: rtl/sd_busy_watchdog.sv
// Busy-line watchdog: counts enabled cycles and flags expiry once TIMEOUT cycles have elapsed.
module sd_busy_watchdog
  import sd_sched_pkg::*;
#(
  parameter logic [TIMEOUT_W-1:0] TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  logic [TIMEOUT_W-1:0] cnt_r;

  assign expire = en && (cnt_r == (TIMEOUT - TIMEOUT_W'(1)));

  // Elapsed-cycle counter; holds at the limit so expiry cannot wrap around
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_r <= {TIMEOUT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {TIMEOUT_W{1'b0}};
    end else if (en && !expire) begin
      cnt_r <= cnt_r + TIMEOUT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/sd_sector_scheduler.sv
// Sector write scheduler for the SD SPI write controller.
// Optional build macro SD_SECTOR_HEADER_EN adds a 3-word sector header and the hdr_sel output.
module sd_sector_scheduler
  import sd_sched_pkg::*;
#(
  parameter int unsigned          WORDS_PER_SECTOR = DEF_WORDS_PER_SECTOR,
  parameter logic [31:0]          START_SECTOR     = DEF_START_SECTOR,
  parameter logic [31:0]          END_SECTOR       = DEF_END_SECTOR,
  parameter logic [TIMEOUT_W-1:0] BUSY_TIMEOUT     = DEF_BUSY_TIMEOUT
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic [11:0] fifo_count,
  input  logic        flush_req,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic        pad_sel,
  output logic        sector_done,
  output logic [31:0] sectors_written,
  output logic        timeout_err,
  output logic        idle
`ifdef SD_SECTOR_HEADER_EN
  ,
  output logic [1:0]  hdr_sel
`endif
);

`ifdef SD_SECTOR_HEADER_EN
  localparam logic [9:0] HDR_LEN = 10'd3;
`else
  localparam logic [9:0] HDR_LEN = 10'd0;
`endif
  localparam logic [11:0] FULL_THRESH = 12'(WORDS_PER_SECTOR) - {2'b00, HDR_LEN};

  sched_state_e state_r, state_nxt_s;
  logic         flush_pend_r;
  logic [8:0]   pad_thresh_r;
  logic [8:0]   word_cnt_r;
  logic         busy_d_r;
  logic         busy_fall_s;
  logic         launch_full_s, launch_flush_s, flush_drop_s, timeout_hit_s;
  logic         wd_en_s, wd_expire_s;
  logic         wr_en_r, sector_done_r, idle_r, timeout_err_r;
  logic [31:0]  wr_addr_r, sectors_written_r;

  assign busy_fall_s = busy_d_r && !wr_busy;
  assign wd_en_s     = (state_r == S_BUSY_WAIT) || (state_r == S_BUSY);

  sd_busy_watchdog #(.TIMEOUT(BUSY_TIMEOUT)) u_watchdog (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (wd_en_s),
    .clr       (!wd_en_s),
    .expire    (wd_expire_s)
  );

  // Next-state decode; losing init_end aborts from every state but S_NEXT
  always_comb begin
    state_nxt_s    = state_r;
    launch_full_s  = 1'b0;
    launch_flush_s = 1'b0;
    flush_drop_s   = 1'b0;
    timeout_hit_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (init_end) state_nxt_s = S_WAIT;
        else          state_nxt_s = S_IDLE;
      end
      S_WAIT: begin
        if (!init_end) begin
          state_nxt_s = S_IDLE;
        end else if (wr_busy) begin
          state_nxt_s = S_WAIT;
        end else if (fifo_count >= FULL_THRESH) begin
          launch_full_s = 1'b1;
          state_nxt_s   = S_START;
        end else if (flush_pend_r && (fifo_count != 12'd0)) begin
          launch_flush_s = 1'b1;
          state_nxt_s    = S_START;
        end else if (flush_pend_r) begin
          flush_drop_s = 1'b1;
          state_nxt_s  = S_WAIT;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_START: begin
        if (!init_end) state_nxt_s = S_IDLE;
        else           state_nxt_s = S_BUSY_WAIT;
      end
      S_BUSY_WAIT: begin
        if (!init_end) begin
          state_nxt_s = S_IDLE;
        end else if (wd_expire_s) begin
          timeout_hit_s = 1'b1;
          state_nxt_s   = S_IDLE;
        end else if (wr_busy) begin
          state_nxt_s = S_BUSY;
        end else begin
          state_nxt_s = S_BUSY_WAIT;
        end
      end
      S_BUSY: begin
        if (!init_end) begin
          state_nxt_s = S_IDLE;
        end else if (busy_fall_s) begin
          state_nxt_s = S_NEXT;
        end else if (wd_expire_s) begin
          timeout_hit_s = 1'b1;
          state_nxt_s   = S_IDLE;
        end else begin
          state_nxt_s = S_BUSY;
        end
      end
      S_NEXT:  state_nxt_s = S_WAIT;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_r <= S_IDLE;
    else            state_r <= state_nxt_s;
  end

  // Flush request latch; a new request wins over a same-cycle clear
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                          flush_pend_r <= 1'b0;
    else if (flush_req)                      flush_pend_r <= 1'b1;
    else if (launch_flush_s || flush_drop_s) flush_pend_r <= 1'b0;
    else                                     flush_pend_r <= flush_pend_r;
  end

  // Sector datapath: valid-word threshold, popped-word count, busy history
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pad_thresh_r <= 9'd0;
      word_cnt_r   <= 9'd0;
      busy_d_r     <= 1'b0;
    end else begin
      busy_d_r <= wr_busy;
      if (launch_full_s)       pad_thresh_r <= FULL_THRESH[8:0];
      else if (launch_flush_s) pad_thresh_r <= fifo_count[8:0];
      else                     pad_thresh_r <= pad_thresh_r;
      if (state_r == S_START)                 word_cnt_r <= 9'd0;
      else if ((state_r == S_BUSY) && wr_req) word_cnt_r <= word_cnt_r + 9'd1;
      else                                    word_cnt_r <= word_cnt_r;
    end
  end

  // Registered status outputs, updated on entry to the corresponding state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_en_r           <= 1'b0;
      sector_done_r     <= 1'b0;
      idle_r            <= 1'b0;
      timeout_err_r     <= 1'b0;
      wr_addr_r         <= START_SECTOR;
      sectors_written_r <= 32'd0;
    end else begin
      wr_en_r       <= (state_nxt_s == S_START);
      sector_done_r <= (state_nxt_s == S_NEXT);
      idle_r        <= (state_nxt_s == S_IDLE) || (state_nxt_s == S_WAIT);
      timeout_err_r <= timeout_err_r || timeout_hit_s;
      if (state_nxt_s == S_NEXT) begin
        wr_addr_r <= (wr_addr_r == END_SECTOR) ? START_SECTOR : (wr_addr_r + 32'd1);
        if (sectors_written_r != 32'hFFFF_FFFF) sectors_written_r <= sectors_written_r + 32'd1;
        else                                    sectors_written_r <= sectors_written_r;
      end else begin
        wr_addr_r         <= wr_addr_r;
        sectors_written_r <= sectors_written_r;
      end
    end
  end

  // Padding must be valid in the same cycle as the pop strobe, so it is decoded combinationally
  assign pad_sel = (state_r == S_BUSY) &&
                   ({1'b0, word_cnt_r} >= (HDR_LEN + {1'b0, pad_thresh_r}));

`ifdef SD_SECTOR_HEADER_EN
  assign hdr_sel = ((state_r == S_BUSY) && (word_cnt_r < 9'd3)) ?
                   (word_cnt_r[1:0] + 2'd1) : 2'd0;
`endif

  assign wr_en           = wr_en_r;
  assign sector_done     = sector_done_r;
  assign idle            = idle_r;
  assign timeout_err     = timeout_err_r;
  assign wr_addr         = wr_addr_r;
  assign sectors_written = sectors_written_r;

endmodule

// File: tb/tb_sd_sector_scheduler.sv
// Self-checking bench for sd_sector_scheduler: table vectors, hand-written corner sequences
// and randomized fill/flush patterns against a sector-level reference model.
module tb_sd_sector_scheduler;

  localparam logic [31:0] START = 32'd1000;
  localparam logic [31:0] ENDS  = 32'd1003;
  localparam int          TMO   = 400;

  logic        sys_clk, sys_rst_n, init_end, flush_req, wr_busy, wr_req;
  logic [11:0] fifo_count;
  logic        wr_en, pad_sel, sector_done, timeout_err, idle;
  logic [31:0] wr_addr, sectors_written;
`ifdef SD_SECTOR_HEADER_EN
  logic [1:0]  hdr_sel;
`endif

  sd_sector_scheduler #(
    .WORDS_PER_SECTOR (256),
    .START_SECTOR     (START),
    .END_SECTOR       (ENDS),
    .BUSY_TIMEOUT     (24'(TMO))
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .init_end        (init_end),
    .fifo_count      (fifo_count),
    .flush_req       (flush_req),
    .wr_busy         (wr_busy),
    .wr_req          (wr_req),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .pad_sel         (pad_sel),
    .sector_done     (sector_done),
    .sectors_written (sectors_written),
    .timeout_err     (timeout_err),
    .idle            (idle)
`ifdef SD_SECTOR_HEADER_EN
    ,
    .hdr_sel         (hdr_sel)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_addr = START;
  logic [31:0] exp_cnt  = 32'd0;
  bit          model_pend = 1'b0;
  int          hold_extra = 0;

  typedef struct {
    int fifo;
    bit flush;
    bit exp_launch;
    int exp_valid;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Sector-level rule: full sector first, else a pending flush with data, else drop an empty flush
  function automatic bit predict(input int fifo, output int valid);
    valid = 0;
    if (fifo >= 256) begin
      valid = 256;
      return 1'b1;
    end
    if (model_pend && fifo > 0) begin
      valid = fifo;
      model_pend = 1'b0;
      return 1'b1;
    end
    model_pend = 1'b0;
    return 1'b0;
  endfunction

  task automatic wait_wr_en(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      if (wr_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
  endtask

  // Act as the SD controller for one sector, starting at the negedge where wr_en is seen
  task automatic service(input int valid);
    int first_pad, npad;
    bit done_seen;
    logic [31:0] prev;
    check("wr_addr_launch", wr_addr, exp_addr);
    wr_busy = 1'b1;
    @(negedge sys_clk);
    check("wr_en_one_cycle", 32'(wr_en), 32'd0);
    @(negedge sys_clk);
    first_pad = 256;
    npad = 0;
    for (int i = 0; i < 256; i++) begin
      wr_req = 1'b1;
      if (pad_sel === 1'b1) begin
        npad++;
        if (first_pad == 256) first_pad = i;
      end
      @(negedge sys_clk);
    end
    wr_req = 1'b0;
    repeat (hold_extra) @(negedge sys_clk);
    check("pad_first_word", 32'(first_pad), 32'(valid));
    check("pad_word_count", 32'(npad), 32'(256 - valid));
    wr_busy = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      if (sector_done === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
    end
    check("sector_done_seen", 32'(done_seen), 32'd1);
    prev = exp_addr;
    exp_addr = (prev == ENDS) ? START : prev + 32'd1;
    exp_cnt = exp_cnt + 32'd1;
    check("wr_addr_next", wr_addr, exp_addr);
    check("sectors_written", sectors_written, exp_cnt);
    if (prev == ENDS) check("wr_addr_wrap", wr_addr, START);
    @(negedge sys_clk);
    check("sector_done_one_cycle", 32'(sector_done), 32'd0);
  endtask

  task automatic step(input int fifo, input bit flush, input bit use_exp,
                      input bit exp_launch, input int exp_valid);
    bit pl, seen;
    int pv, cur;
    @(negedge sys_clk);
    fifo_count = 12'(fifo);
    flush_req  = flush;
    if (flush) model_pend = 1'b1;
    pl = predict(fifo, pv);
    if (use_exp) begin
      pl = exp_launch;
      pv = exp_valid;
    end
    @(negedge sys_clk);
    flush_req = 1'b0;
    wait_wr_en(6, seen);
    check("launch", 32'(seen), 32'(pl));
    if (!seen) check("idle_no_launch", 32'(idle), 32'd1);
    cur = fifo;
    for (int k = 0; k < 4; k++) begin
      if (!(seen && pl)) break;
      cur = cur - pv;
      fifo_count = 12'(cur);
      service(pv);
      pl = predict(cur, pv);
      wait_wr_en(6, seen);
      check("launch_follow", 32'(seen), 32'(pl));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit seen, done_seen, tmo_seen;
    int tmo_k;
    vecs[0] = '{256, 1'b0, 1'b1, 256};
    vecs[1] = '{300, 1'b0, 1'b1, 256};
    vecs[2] = '{255, 1'b0, 1'b0, 0};
    vecs[3] = '{100, 1'b1, 1'b1, 100};
    vecs[4] = '{0,   1'b1, 1'b0, 0};
    vecs[5] = '{1,   1'b1, 1'b1, 1};
    vecs[6] = '{255, 1'b1, 1'b1, 255};
    vecs[7] = '{0,   1'b0, 1'b0, 0};
    vecs[8] = '{300, 1'b1, 1'b1, 256};

    sys_rst_n = 1'b0; init_end = 1'b0; flush_req = 1'b0;
    wr_busy = 1'b0; wr_req = 1'b0; fifo_count = 12'd0;
    repeat (3) @(negedge sys_clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", wr_addr, START);
    check("rst_pad_sel", 32'(pad_sel), 32'd0);
    check("rst_sector_done", 32'(sector_done), 32'd0);
    check("rst_sectors_written", sectors_written, 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_idle", 32'(idle), 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("idle_after_reset", 32'(idle), 32'd1);
    fifo_count = 12'd256;
    repeat (4) @(negedge sys_clk);
    check("no_wr_en_before_init", 32'(wr_en), 32'd0);
    fifo_count = 12'd0;
    init_end = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int i = 0; i < 9; i++)
      step(vecs[i].fifo, vecs[i].flush, 1'b1, vecs[i].exp_launch, vecs[i].exp_valid);

    // init_end drops mid-sector: abort, then the same address is rewritten
    @(negedge sys_clk);
    fifo_count = 12'd256;
    wait_wr_en(6, seen);
    check("abort_launch", 32'(seen), 32'd1);
    fifo_count = 12'd0;
    wr_busy = 1'b1;
    repeat (2) @(negedge sys_clk);
    for (int i = 0; i < 50; i++) begin
      wr_req = 1'b1;
      @(negedge sys_clk);
    end
    wr_req = 1'b0;
    init_end = 1'b0;
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      if (sector_done === 1'b1) done_seen = 1'b1;
    end
    check("abort_idle", 32'(idle), 32'd1);
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_addr_kept", wr_addr, exp_addr);
    check("abort_count_kept", sectors_written, exp_cnt);
    wr_busy = 1'b0;
    fifo_count = 12'd256;
    @(negedge sys_clk);
    init_end = 1'b1;
    wait_wr_en(8, seen);
    check("abort_relaunch", 32'(seen), 32'd1);
    fifo_count = 12'd0;
    if (seen) service(256);

    for (int i = 0; i < 8; i++) begin
      hold_extra = int'($urandom_range(0, 20));
      step(int'($urandom_range(0, 600)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0);
    end
    hold_extra = 0;

    // wr_busy stuck high: watchdog fires after TMO cycles, no completion
    @(negedge sys_clk);
    fifo_count = 12'd256;
    wait_wr_en(6, seen);
    check("tmo_launch", 32'(seen), 32'd1);
    fifo_count = 12'd0;
    wr_busy = 1'b1;
    done_seen = 1'b0;
    tmo_seen = 1'b0;
    tmo_k = -1;
    for (int k = 0; k < TMO + 200; k++) begin
      @(negedge sys_clk);
      if (sector_done === 1'b1) done_seen = 1'b1;
      if (timeout_err === 1'b1) begin
        tmo_seen = 1'b1;
        tmo_k = k;
        break;
      end
    end
    check("tmo_err_set", 32'(tmo_seen), 32'd1);
    check("tmo_latency", 32'(tmo_k), 32'(TMO));
    check("tmo_idle", 32'(idle), 32'd1);
    check("tmo_addr_kept", wr_addr, exp_addr);
    check("tmo_no_done", 32'(done_seen), 32'd0);
    check("tmo_count_kept", sectors_written, exp_cnt);
    fifo_count = 12'd256;
    seen = 1'b0;
    repeat (20) begin
      @(negedge sys_clk);
      if (wr_en === 1'b1) seen = 1'b1;
    end
    check("no_wr_en_while_busy", 32'(seen), 32'd0);
    wr_busy = 1'b0;
    wait_wr_en(8, seen);
    check("tmo_relaunch", 32'(seen), 32'd1);
    fifo_count = 12'd0;
    if (seen) service(256);
    check("tmo_sticky", 32'(timeout_err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
